// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared types and widths for the register-file write arbiter
package reg_write_arbiter_pkg;

    localparam int REG_ID_W = 5;
    localparam int DATA_W   = 32;
    localparam logic [REG_ID_W-1:0] ZERO_REG = '0;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        OVERRIDE = 1'b1
    } arb_state_e;

    function automatic logic is_zero_reg(input logic [REG_ID_W-1:0] id);
        return id == ZERO_REG;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_starve_counter.sv
// rtl/reg_write_arbiter_starve_counter.sv - saturating stall counter with clear and terminal-count flag
module starve_counter
    import reg_write_arbiter_pkg::*;
#(
    parameter int LIMIT = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic terminal
);

    localparam logic [STARVE_CNT_W-1:0] TERM_CNT = STARVE_CNT_W'(LIMIT - 1);
    localparam logic [STARVE_CNT_W-1:0] MAX_CNT  = '1;

    logic [STARVE_CNT_W-1:0] count;

    // Clear wins over increment so entering OVERRIDE restarts the count from zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_CNT)) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TERM_CNT);

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register-file write arbiter with starvation override
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wb_valid,
    input  logic [REG_ID_W-1:0] wb_id,
    input  logic [DATA_W-1:0]   wb_value,
    output logic                wb_ready,
    input  logic                mc_valid,
    input  logic [REG_ID_W-1:0] mc_id,
    input  logic [DATA_W-1:0]   mc_value,
    output logic                mc_ready,
    output logic                control_reg_write,
    output logic [REG_ID_W-1:0] control_write_id,
    output logic [DATA_W-1:0]   reg_write_value,
    output logic                wb_stall
);

    arb_state_e state;
    arb_state_e state_next;

    logic wb_xfer;
    logic mc_xfer;
    logic mc_stalled;
    logic starve_term;
    logic enter_override;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // OVERRIDE only ever lasts one cycle: requester 1 either transfers or has dropped valid.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL:   if (enter_override) state_next = OVERRIDE;
            OVERRIDE: state_next = NORMAL;
            default:  state_next = NORMAL;
        endcase
    end

    always_comb begin
        wb_ready = 1'b1;
        mc_ready = 1'b0;
        case (state)
            NORMAL: begin
                wb_ready = 1'b1;
                mc_ready = ~wb_valid;
            end
            OVERRIDE: begin
                mc_ready = 1'b1;
                wb_ready = ~mc_valid;
            end
            default: begin
                wb_ready = 1'b1;
                mc_ready = ~wb_valid;
            end
        endcase
    end

    assign wb_stall       = wb_valid & ~wb_ready;
    assign wb_xfer        = wb_valid & wb_ready;
    assign mc_xfer        = mc_valid & mc_ready;
    assign mc_stalled     = (state == NORMAL) & mc_valid & ~mc_ready;
    assign enter_override = mc_stalled & starve_term;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc      (mc_stalled),
        .clr      (mc_xfer | ~mc_valid | enter_override),
        .terminal (starve_term)
    );

    // Id-0 transfers are accepted but leave the write port untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            control_reg_write <= 1'b0;
            control_write_id  <= '0;
            reg_write_value   <= '0;
        end else if (wb_xfer && !is_zero_reg(wb_id)) begin
            control_reg_write <= 1'b1;
            control_write_id  <= wb_id;
            reg_write_value   <= wb_value;
        end else if (mc_xfer && !is_zero_reg(mc_id)) begin
            control_reg_write <= 1'b1;
            control_write_id  <= mc_id;
            reg_write_value   <= mc_value;
        end else begin
            control_reg_write <= 1'b0;
        end
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, legal range 1..15; the number of consecutive stalled cycles for requester 1 before it is forced to win.
REQ-002 Port: clock  in  1  single clock; all state updates on posedge.
REQ-003 Port: reset_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: wb_valid  in  1  requester 0 (pipeline writeback) has a write pending.
REQ-005 Port: wb_id  in  5  requester 0 destination register.
REQ-006 Port: wb_value  in  32  requester 0 write data.
REQ-007 Port: wb_ready  out  1  requester 0 write accepted this cycle.
REQ-008 Port: mc_valid  in  1  requester 1 (multi-cycle unit) has a write pending.
REQ-009 Port: mc_id  in  5  requester 1 destination register.
REQ-010 Port: mc_value  in  32  requester 1 write data.
REQ-011 Port: mc_ready  out  1  requester 1 write accepted this cycle.
REQ-012 Port: control_reg_write  out  1  write enable to the register file.
REQ-013 Port: control_write_id  out  5  register file write index.
REQ-014 Port: reg_write_value  out  32  register file write data.
REQ-015 Port: wb_stall  out  1  equals wb_valid & ~wb_ready; used by the pipeline to hold writeback.

Function
REQ-016 A transfer on a requester occurs at posedge when its valid and ready are both 1; the requester SHALL hold id/value stable while valid is 1 and ready is 0.
REQ-017 The state machine SHALL have two states: NORMAL (requester 0 priority) and OVERRIDE (requester 1 priority).
REQ-018 In NORMAL: wb_ready = 1; mc_ready = ~wb_valid.
REQ-019 In OVERRIDE: mc_ready = 1; wb_ready = ~mc_valid.
REQ-020 Ready outputs SHALL be combinational from state and valid inputs only; at most one ready-and-valid pair is true per cycle.
REQ-021 Starvation counter: increments each posedge in NORMAL with mc_valid=1 and mc_ready=0; clears on any requester-1 transfer, when mc_valid=0, or on entering OVERRIDE.
REQ-022 NORMAL->OVERRIDE at the posedge where the counter equals STARVE_LIMIT-1 and requester 1 is stalled in that cycle.
REQ-023 OVERRIDE->NORMAL at the next posedge whatever the inputs (transfer of requester 1, or mc_valid low).
REQ-024 Write outputs are registered: the posedge after a transfer, control_reg_write=1 for exactly one cycle with the id/value of the transferred request; with no transfer, control_reg_write=0 and id/value hold their last values.
REQ-025 A transfer with id 0 SHALL complete the handshake, but control_reg_write stays 0 (the write is discarded).
REQ-026 Registered outputs change only at posedge, so they are stable at the register file's negedge write.
REQ-027 Both requesters targeting the same id in one cycle: only the granted one is written; the loser is written in a later cycle (last writer wins).
REQ-028 Latency: request to register-file write enable = 1 cycle when uncontended; requester 1 worst case = STARVE_LIMIT+1 cycles.

Reset
REQ-029 reset_n low SHALL immediately force state=NORMAL, counter=0, control_reg_write=0, control_write_id=0, reg_write_value=0.
REQ-030 Reset asserted mid-stall SHALL discard arbitration history; no write issues from before reset after reset is released.

Structure
REQ-031 A shared package SHALL hold the state enumeration (NORMAL, OVERRIDE) and the register-index width constant (5), the data width (32) and the zero-register index (0).
REQ-032 One sub-module, starve_counter (saturating counter with clear and terminal-count output), SHALL implement REQ-021/REQ-022; everything else is flat.

Verification
REQ-033 Only wb_valid=1, wb_id=5, wb_value=0xDEADBEEF -> next cycle control_reg_write=1, id=5, value=0xDEADBEEF; then 0.
REQ-034 wb_valid and mc_valid held at 1 continuously, STARVE_LIMIT=3 -> grants in the pattern wb,wb,wb,mc, repeating; mc_ready=1 in the fourth cycle only.
REQ-035 mc_valid=1, mc_id=0, no wb request -> mc_ready=1, control_reg_write remains 0.
REQ-036 Both valid with id=7, wb=0x1, mc=0x2 -> wb written first, then mc once granted; the register-file contents read back 0x2.
REQ-037 Assert reset_n=0 asynchronously in OVERRIDE with a write pending -> outputs are 0 at once, state=NORMAL; after release the first contended cycle grants wb.
REQ-038 Random valid/id/value with stable-payload protocol -> scoreboard: each transfer yields exactly one write (none for id 0) in order; no mc wait exceeds STARVE_LIMIT+1 cycles.
